// File: rtl/rtermcal_pkg.sv
// Shared types and helpers for the RTERMCAL successive-approximation controller.
// Holds the FSM encoding, counter sizing, thermometer and saturation helpers.
package rtermcal_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StNextCh,
    StSetup,
    StSettle,
    StSample,
    StDecide,
    StDone
  } state_e;

  localparam int unsigned SatLoCode = 0;

  // Bits needed for a counter spanning 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic therm_bit(input int unsigned code, input int unsigned idx);
    return code > idx;
  endfunction

  function automatic logic code_is_sat(input int unsigned code, input int unsigned w);
    return (code == SatLoCode) || (code == ((32'd1 << w) - 32'd1));
  endfunction

endpackage

// File: rtl/rtermcal_therm_enc.sv
// Binary-to-thermometer encoder: code k drives bits [k-1:0] high.
module rtermcal_therm_enc
  import rtermcal_pkg::*;
#(
  parameter int unsigned CODE_W = 4
) (
  input  logic [CODE_W-1:0]      code_i,
  output logic [2**CODE_W-2:0]   therm_o
);

  always_comb begin
    therm_o = '0;
    for (int unsigned i = 0; i < 2**CODE_W - 1; i++) begin
      therm_o[i] = therm_bit(int'(code_i), i);
    end
  end

endmodule

// File: rtl/rtermcal_sar_ctrl.sv
// Multi-channel termination trim calibration: per-channel SAR search with settle time
// and majority-voted comparator sampling, driving thermometer or binary trial codes.
module rtermcal_sar_ctrl
  import rtermcal_pkg::*;
#(
  parameter int unsigned       NUM_CH     = 2,
  parameter int unsigned       CODE_W     = 4,
  parameter logic [NUM_CH-1:0] CH_THERMO  = 2'b01,
  parameter int unsigned       SETTLE_CYC = 16,
  parameter int unsigned       NSAMP      = 3
) (
  input  logic                               CLK_I,
  input  logic                               RST_I,
  input  logic                               START_I,
  input  logic [NUM_CH-1:0]                  CH_EN_I,
  input  logic [NUM_CH-1:0]                  COMP_I,
  output logic [NUM_CH-1:0]                  MODE_O,
  output logic [NUM_CH*(2**CODE_W-1)-1:0]    DRV_O,
  output logic [NUM_CH*CODE_W-1:0]           CODE_O,
  output logic                               BUSY_O,
  output logic                               DONE_O,
  output logic [NUM_CH-1:0]                  SAT_O
);

  localparam int unsigned ThW   = 2**CODE_W - 1;
  localparam int unsigned ChW   = cnt_w(NUM_CH);
  localparam int unsigned CntW  = cnt_w((SETTLE_CYC > NSAMP) ? SETTLE_CYC : NSAMP);
  localparam int unsigned OnesW = cnt_w(NSAMP + 1);

  state_e                         state_q, state_d;
  logic [NUM_CH-1:0]              pend_q, pend_d;
  logic [ChW-1:0]                 ch_q, ch_d;
  logic [CODE_W-1:0]              work_q, work_d;
  logic [CODE_W-1:0]              bit_q, bit_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [OnesW-1:0]               ones_q, ones_d;
  logic                           first_q, first_d;
  logic [NUM_CH-1:0][CODE_W-1:0]  drv_code_q, drv_code_d;
  logic [NUM_CH-1:0][CODE_W-1:0]  code_q, code_d;
  logic [NUM_CH-1:0]              sat_q, sat_d;

  logic                           sel_valid;
  logic [ChW-1:0]                 sel_ch;
  logic [CODE_W-1:0]              final_code;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= StIdle;
      pend_q     <= '0;
      ch_q       <= '0;
      work_q     <= '0;
      bit_q      <= '0;
      cnt_q      <= '0;
      ones_q     <= '0;
      first_q    <= 1'b0;
      drv_code_q <= '0;
      code_q     <= '0;
      sat_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      ch_q       <= ch_d;
      work_q     <= work_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      ones_q     <= ones_d;
      first_q    <= first_d;
      drv_code_q <= drv_code_d;
      code_q     <= code_d;
      sat_q      <= sat_d;
    end
  end

  // Lowest-index pending channel wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_valid = 1'b1;
        sel_ch    = ChW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    ch_d       = ch_q;
    work_d     = work_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    ones_d     = ones_q;
    first_d    = first_q;
    drv_code_d = drv_code_q;
    code_d     = code_q;
    sat_d      = sat_q;
    final_code = work_q;

    unique case (state_q)
      StIdle: begin
        if (START_I) begin
          pend_d  = CH_EN_I;
          first_d = 1'b1;
          state_d = StNextCh;
        end
      end
      StNextCh: begin
        if (sel_valid) begin
          ch_d          = sel_ch;
          pend_d[sel_ch] = 1'b0;
          work_d        = '0;
          bit_d         = CODE_W'(1) << (CODE_W - 1);
          first_d       = 1'b0;
          state_d       = StSetup;
        end else if (first_q) begin
          // An empty mask still spends one selection cycle before finishing.
          first_d = 1'b0;
        end else begin
          state_d = StDone;
        end
      end
      StSetup: begin
        work_d           = work_q | bit_q;
        drv_code_d[ch_q] = work_q | bit_q;
        cnt_d            = '0;
        state_d          = StSettle;
      end
      StSettle: begin
        if (cnt_q == CntW'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          ones_d  = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSample: begin
        ones_d = ones_q + OnesW'(COMP_I[ch_q]);
        if (cnt_q == CntW'(NSAMP - 1)) begin
          cnt_d   = '0;
          state_d = StDecide;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDecide: begin
        // Majority says trimmed R is still too low: this bit overshoots.
        final_code = (ones_q > OnesW'(NSAMP / 2)) ? (work_q & ~bit_q) : work_q;
        work_d     = final_code;
        bit_d      = bit_q >> 1;
        ones_d     = '0;
        if (bit_q[0]) begin
          code_d[ch_q]     = final_code;
          sat_d[ch_q]      = code_is_sat(int'(final_code), CODE_W);
          drv_code_d[ch_q] = final_code;
          state_d          = StNextCh;
        end else begin
          state_d = StSetup;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    MODE_O = '0;
    if (state_q inside {StSetup, StSettle, StSample, StDecide}) begin
      MODE_O = NUM_CH'(1) << ch_q;
    end
  end

  assign BUSY_O = (state_q != StIdle) && (state_q != StDone);
  assign DONE_O = (state_q == StDone);
  assign SAT_O  = sat_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign CODE_O[c*CODE_W +: CODE_W] = code_q[c];
    if (CH_THERMO[c]) begin : g_therm
      rtermcal_therm_enc #(
        .CODE_W (CODE_W)
      ) u_enc (
        .code_i  (drv_code_q[c]),
        .therm_o (DRV_O[c*ThW +: ThW])
      );
    end else begin : g_bin
      assign DRV_O[c*ThW +: ThW] = ThW'(drv_code_q[c]);
    end
  end

endmodule

// File: tb/tb_rtermcal_sar_ctrl.sv
// Directed bench for rtermcal_sar_ctrl with a threshold comparator model per channel.
module tb_rtermcal_sar_ctrl;

  localparam int unsigned NumCh = 2;
  localparam int unsigned CodeW = 4;
  localparam int unsigned ThW   = 15;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [NumCh-1:0]       ch_en = '0;
  logic [NumCh-1:0]       comp;
  logic [NumCh-1:0]       mode;
  logic [NumCh*ThW-1:0]   drv;
  logic [NumCh*CodeW-1:0] code;
  logic                   busy;
  logic                   done;
  logic [NumCh-1:0]       sat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int comp_mode = 0;  // 0 threshold, 1 always 0, 2 always 1, 3 threshold + noise
  int tr0;
  int tr1;

  rtermcal_sar_ctrl #(
    .NUM_CH     (2),
    .CODE_W     (4),
    .CH_THERMO  (2'b01),
    .SETTLE_CYC (4),
    .NSAMP      (3)
  ) dut (
    .CLK_I   (clk),
    .RST_I   (rst),
    .START_I (start),
    .CH_EN_I (ch_en),
    .COMP_I  (comp),
    .MODE_O  (mode),
    .DRV_O   (drv),
    .CODE_O  (code),
    .BUSY_O  (busy),
    .DONE_O  (done),
    .SAT_O   (sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator model: ch0 is thermometer (trial = popcount), ch1 is binary.
  always_comb begin
    tr0 = 0;
    for (int i = 0; i < ThW; i++) tr0 += int'(drv[i]);
    tr1 = int'(drv[ThW +: CodeW]);
    comp[1] = (tr1 > 5);
    case (comp_mode)
      1:       comp[0] = 1'b0;
      2:       comp[0] = 1'b1;
      3:       comp[0] = (tr0 > 9) ^ ((cyc % 3) == 0);
      default: comp[0] = (tr0 > 9);
    endcase
  end

  task automatic run_cal(input logic [1:0] en, input int inj_k, output int done_at,
                         output logic saw_m0, output logic busy_mid);
    done_at  = -1;
    saw_m0   = 1'b0;
    busy_mid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    ch_en = en;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5) ch_en = ~en;
      if (k == inj_k) start = 1'b1;
      if (k == 10) busy_mid = busy;
      if (mode == 2'b01) saw_m0 = 1'b1;
      if (done) begin
        done_at = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got done=%b busy=%b want 0 0", done, busy);
    end
    checks++;
    if (mode !== '0 || sat !== '0) begin
      errors++;
      $display("FAIL reset_mode_sat got mode=%b sat=%b want 0 0", mode, sat);
    end
    checks++;
    if (drv !== '0 || code !== '0) begin
      errors++;
      $display("FAIL reset_data got drv=%h code=%h want 0 0", drv, code);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int d;
    logic m0;
    logic b;
    comp_mode = 0;
    run_cal(2'b11, 0, d, m0, b);
    checks++;
    if (d != 75) begin
      errors++;
      $display("FAIL basic_done_cycle got %0d want 75", d);
    end
    checks++;
    if (b !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b want 1", b);
    end
    checks++;
    if (code !== 8'h59) begin
      errors++;
      $display("FAIL basic_code got %h want 59", code);
    end
    checks++;
    if (drv !== {15'h0005, 15'h01FF}) begin
      errors++;
      $display("FAIL basic_drv got %h want %h", drv, {15'h0005, 15'h01FF});
    end
    checks++;
    if (sat !== 2'b00) begin
      errors++;
      $display("FAIL basic_sat got %b want 00", sat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mode !== 2'b00) begin
      errors++;
      $display("FAIL basic_after_done got done=%b busy=%b mode=%b want 0 0 00", done, busy, mode);
    end
  endtask

  task automatic test_saturation();
    int d;
    logic m0;
    logic b;
    comp_mode = 1;
    run_cal(2'b01, 0, d, m0, b);
    checks++;
    if (d != 38) begin
      errors++;
      $display("FAIL sat_hi_done_cycle got %0d want 38", d);
    end
    checks++;
    if (code !== 8'h5F || sat !== 2'b01) begin
      errors++;
      $display("FAIL sat_hi got code=%h sat=%b want 5f 01", code, sat);
    end
    checks++;
    if (drv[ThW-1:0] !== 15'h7FFF) begin
      errors++;
      $display("FAIL sat_hi_drv got %h want 7fff", drv[ThW-1:0]);
    end
    comp_mode = 2;
    run_cal(2'b01, 0, d, m0, b);
    checks++;
    if (code !== 8'h50 || sat !== 2'b01) begin
      errors++;
      $display("FAIL sat_lo got code=%h sat=%b want 50 01", code, sat);
    end
    checks++;
    if (drv[ThW-1:0] !== 15'h0000) begin
      errors++;
      $display("FAIL sat_lo_drv got %h want 0000", drv[ThW-1:0]);
    end
  endtask

  task automatic test_noise();
    int d;
    logic m0;
    logic b;
    comp_mode = 3;
    run_cal(2'b01, 0, d, m0, b);
    checks++;
    if (code !== 8'h59 || sat !== 2'b00) begin
      errors++;
      $display("FAIL noise_code got code=%h sat=%b want 59 00", code, sat);
    end
    comp_mode = 0;
  endtask

  task automatic test_masking();
    int d;
    logic m0;
    logic b;
    comp_mode = 0;
    run_cal(2'b10, 0, d, m0, b);
    checks++;
    if (d != 38) begin
      errors++;
      $display("FAIL mask_ch1_done_cycle got %0d want 38", d);
    end
    checks++;
    if (m0 !== 1'b0) begin
      errors++;
      $display("FAIL mask_ch1_mode got saw_mode01=%b want 0", m0);
    end
    checks++;
    if (code !== 8'h59) begin
      errors++;
      $display("FAIL mask_ch1_code got %h want 59", code);
    end
    run_cal(2'b00, 0, d, m0, b);
    checks++;
    if (d != 2) begin
      errors++;
      $display("FAIL mask_none_done_cycle got %0d want 2", d);
    end
    checks++;
    if (code !== 8'h59 || sat !== 2'b00) begin
      errors++;
      $display("FAIL mask_none_code got code=%h sat=%b want 59 00", code, sat);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    logic m0;
    logic b;
    comp_mode = 0;
    run_cal(2'b11, 20, d, m0, b);
    checks++;
    if (d != 75) begin
      errors++;
      $display("FAIL restart_done_cycle got %0d want 75", d);
    end
    checks++;
    if (code !== 8'h59) begin
      errors++;
      $display("FAIL restart_code got %h want 59", code);
    end
  endtask

  task automatic test_reset_mid();
    int d;
    logic m0;
    logic b;
    logic saw_done;
    comp_mode = 0;
    @(negedge clk);
    start = 1'b1;
    ch_en = 2'b11;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 30; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || mode !== '0) begin
      errors++;
      $display("FAIL midrst_ctl got done=%b busy=%b mode=%b want 0 0 0", done, busy, mode);
    end
    checks++;
    if (drv !== '0 || code !== '0 || sat !== '0) begin
      errors++;
      $display("FAIL midrst_data got drv=%h code=%h sat=%b want 0 0 0", drv, code, sat);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_done got activity=%b want 0", saw_done);
    end
    run_cal(2'b11, 0, d, m0, b);
    checks++;
    if (d != 75 || code !== 8'h59) begin
      errors++;
      $display("FAIL midrst_rerun got done_at=%0d code=%h want 75 59", d, code);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_noise();
    test_masking();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
